// File: rtl/aib_avmm_arb2.sv
// Two-master Avalon-MM arbiter sharing one 32-bit slave port.
// Round-robin grant held for a full transaction, with a read-response timeout.
module aib_avmm_arb2 #(
    parameter int ADDR_WIDTH = 8,
    parameter int TMO_WIDTH  = 8
) (
    input  logic                  avmm_clk,
    input  logic                  avmm_rst_n,
    input  logic                  i_m0_write,
    input  logic                  i_m0_read,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [31:0]           i_m0_wdata,
    input  logic [3:0]            i_m0_byte_en,
    output logic [31:0]           o_m0_rdata,
    output logic                  o_m0_rdatavalid,
    output logic                  o_m0_waitrequest,
    input  logic                  i_m1_write,
    input  logic                  i_m1_read,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [31:0]           i_m1_wdata,
    input  logic [3:0]            i_m1_byte_en,
    output logic [31:0]           o_m1_rdata,
    output logic                  o_m1_rdatavalid,
    output logic                  o_m1_waitrequest,
    output logic                  o_s_write,
    output logic                  o_s_read,
    output logic [ADDR_WIDTH-1:0] o_s_addr,
    output logic [31:0]           o_s_wdata,
    output logic [3:0]            o_s_byte_en,
    input  logic [31:0]           i_s_rdata,
    input  logic                  i_s_rdatavalid,
    input  logic                  i_s_waitrequest,
    output logic                  o_rd_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic [TMO_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

    logic req_m0, req_m1;
    logic g_write, g_read;

    always_comb begin
        req_m0  = i_m0_write | i_m0_read;
        req_m1  = i_m1_write | i_m1_read;
        g_write = grant_q ? i_m1_write : i_m0_write;
        g_read  = grant_q ? i_m1_read  : i_m0_read;

        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tmo_cnt_d    = tmo_cnt_q;

        o_s_write        = 1'b0;
        o_s_read         = 1'b0;
        o_s_addr         = '0;
        o_s_wdata        = '0;
        o_s_byte_en      = '0;
        o_m0_waitrequest = 1'b1;
        o_m1_waitrequest = 1'b1;
        o_m0_rdatavalid  = 1'b0;
        o_m1_rdatavalid  = 1'b0;
        o_m0_rdata       = '0;
        o_m1_rdata       = '0;
        o_rd_timeout     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_m0 || req_m1) begin
                    // On a tie the master that did not complete last wins.
                    grant_d = (req_m0 && req_m1) ? ~last_grant_q : req_m1;
                    state_d = CMD;
                end
            end
            CMD: begin
                o_s_write   = g_write;
                o_s_read    = g_read & ~g_write;
                o_s_addr    = grant_q ? i_m1_addr    : i_m0_addr;
                o_s_wdata   = grant_q ? i_m1_wdata   : i_m0_wdata;
                o_s_byte_en = grant_q ? i_m1_byte_en : i_m0_byte_en;
                if (grant_q) o_m1_waitrequest = i_s_waitrequest;
                else         o_m0_waitrequest = i_s_waitrequest;

                if (!(g_write || g_read)) begin
                    state_d = IDLE;
                end else if (!i_s_waitrequest) begin
                    if (g_write) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        tmo_cnt_d = '0;
                        state_d   = RDWAIT;
                    end
                end
            end
            RDWAIT: begin
                if (i_s_rdatavalid) begin
                    if (grant_q) begin
                        o_m1_rdatavalid = 1'b1;
                        o_m1_rdata      = i_s_rdata;
                    end else begin
                        o_m0_rdatavalid = 1'b1;
                        o_m0_rdata      = i_s_rdata;
                    end
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else if (tmo_cnt_q == '1) begin
                    if (grant_q) o_m1_rdatavalid = 1'b1;
                    else         o_m0_rdatavalid = 1'b1;
                    o_rd_timeout = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_aib_avmm_arb2.sv
// Directed bench for aib_avmm_arb2: a transaction-level reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_aib_avmm_arb2;

    localparam int AW = 8;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_m0_write, i_m0_read, i_m1_write, i_m1_read;
    logic [AW-1:0] i_m0_addr, i_m1_addr;
    logic [31:0]   i_m0_wdata, i_m1_wdata;
    logic [3:0]    i_m0_byte_en, i_m1_byte_en;
    logic [31:0]   o_m0_rdata, o_m1_rdata;
    logic          o_m0_rdatavalid, o_m1_rdatavalid;
    logic          o_m0_waitrequest, o_m1_waitrequest;
    logic          o_s_write, o_s_read;
    logic [AW-1:0] o_s_addr;
    logic [31:0]   o_s_wdata;
    logic [3:0]    o_s_byte_en;
    logic [31:0]   i_s_rdata;
    logic          i_s_rdatavalid, i_s_waitrequest;
    logic          o_rd_timeout;

    aib_avmm_arb2 #(.ADDR_WIDTH(AW), .TMO_WIDTH(TW)) dut (
        .avmm_clk        (clk),
        .avmm_rst_n      (rst_n),
        .i_m0_write      (i_m0_write),
        .i_m0_read       (i_m0_read),
        .i_m0_addr       (i_m0_addr),
        .i_m0_wdata      (i_m0_wdata),
        .i_m0_byte_en    (i_m0_byte_en),
        .o_m0_rdata      (o_m0_rdata),
        .o_m0_rdatavalid (o_m0_rdatavalid),
        .o_m0_waitrequest(o_m0_waitrequest),
        .i_m1_write      (i_m1_write),
        .i_m1_read       (i_m1_read),
        .i_m1_addr       (i_m1_addr),
        .i_m1_wdata      (i_m1_wdata),
        .i_m1_byte_en    (i_m1_byte_en),
        .o_m1_rdata      (o_m1_rdata),
        .o_m1_rdatavalid (o_m1_rdatavalid),
        .o_m1_waitrequest(o_m1_waitrequest),
        .o_s_write       (o_s_write),
        .o_s_read        (o_s_read),
        .o_s_addr        (o_s_addr),
        .o_s_wdata       (o_s_wdata),
        .o_s_byte_en     (o_s_byte_en),
        .i_s_rdata       (i_s_rdata),
        .i_s_rdatavalid  (i_s_rdatavalid),
        .i_s_waitrequest (i_s_waitrequest),
        .o_rd_timeout    (o_rd_timeout)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    bit    sampled = 0;
    longint cyc = 0;

    // Reference model: who owns the bus, what phase of its transaction it is in,
    // and the absolute cycle at which an unanswered read gives up.
    int     m_phase;   // 0 free, 1 command offered, 2 awaiting read data
    int     m_owner;
    int     m_last;
    longint m_deadline;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic          e_sw, e_sr, e_w0, e_w1, e_v0, e_v1, e_to;
        logic [AW-1:0] e_sa;
        logic [31:0]   e_sd, e_r0, e_r1;
        logic [3:0]    e_be;
        logic          wr, rd;
        logic [114:0]  exp_v, act_v;
        e_sw = 0; e_sr = 0; e_sa = '0; e_sd = '0; e_be = '0;
        e_w0 = 1; e_w1 = 1; e_v0 = 0; e_v1 = 0; e_r0 = '0; e_r1 = '0; e_to = 0;
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_last = 1;
        end else begin
            case (m_phase)
                0: if (i_m0_write || i_m0_read || i_m1_write || i_m1_read) begin
                    if ((i_m0_write || i_m0_read) && (i_m1_write || i_m1_read))
                        m_owner = 1 - m_last;
                    else
                        m_owner = (i_m0_write || i_m0_read) ? 0 : 1;
                    m_phase = 1;
                end
                1: begin
                    wr   = (m_owner == 1) ? i_m1_write : i_m0_write;
                    rd   = (m_owner == 1) ? i_m1_read  : i_m0_read;
                    e_sw = wr;
                    e_sr = rd && !wr;
                    e_sa = (m_owner == 1) ? i_m1_addr    : i_m0_addr;
                    e_sd = (m_owner == 1) ? i_m1_wdata   : i_m0_wdata;
                    e_be = (m_owner == 1) ? i_m1_byte_en : i_m0_byte_en;
                    if (m_owner == 1) e_w1 = i_s_waitrequest; else e_w0 = i_s_waitrequest;
                    if (!(wr || rd)) m_phase = 0;
                    else if (!i_s_waitrequest) begin
                        if (wr) begin m_last = m_owner; m_phase = 0; end
                        else begin m_deadline = cyc + (64'd1 << TW); m_phase = 2; end
                    end
                end
                default: begin
                    if (i_s_rdatavalid || cyc == m_deadline) begin
                        if (m_owner == 1) begin e_v1 = 1; e_r1 = i_s_rdatavalid ? i_s_rdata : 32'h0; end
                        else              begin e_v0 = 1; e_r0 = i_s_rdatavalid ? i_s_rdata : 32'h0; end
                        e_to    = !i_s_rdatavalid;
                        m_last  = m_owner;
                        m_phase = 0;
                    end
                end
            endcase
        end
        exp_v = {e_sw, e_sr, e_sa, e_sd, e_be, e_w0, e_w1, e_v0, e_v1, e_r0, e_r1, e_to};
        act_v = {o_s_write, o_s_read, o_s_addr, o_s_wdata, o_s_byte_en, o_m0_waitrequest,
                 o_m1_waitrequest, o_m0_rdatavalid, o_m1_rdatavalid, o_m0_rdata, o_m1_rdata,
                 o_rd_timeout};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model cycle %0d: got %h expected %h", cyc, act_v, exp_v);
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
        sampled = 1;
    endtask

    task automatic next_cycle();
        if (!sampled) sample();
        @(posedge clk);
        #1;
        sampled = 0;
    endtask

    task automatic clear_inputs();
        i_m0_write = 0; i_m0_read = 0; i_m0_addr = '0; i_m0_wdata = '0; i_m0_byte_en = '0;
        i_m1_write = 0; i_m1_read = 0; i_m1_addr = '0; i_m1_wdata = '0; i_m1_byte_en = '0;
        i_s_rdata = '0; i_s_rdatavalid = 0; i_s_waitrequest = 0;
    endtask

    task automatic reset_dut();
        rst_n = 0;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst_n = 1;
    endtask

    int order [8];
    int n_rv, k, seen_wr, seen_rd, acc_at, stable, pulse_at;
    bit acc, done;

    initial begin
        m_phase = 0; m_owner = 0; m_last = 1; m_deadline = 0;
        rst_n = 0;
        clear_inputs();
        sample();
        chk("reset m0_wait", {31'd0, o_m0_waitrequest}, 32'd1);
        chk("reset m1_wait", {31'd0, o_m1_waitrequest}, 32'd1);
        chk("reset s_cmd", {30'd0, o_s_write, o_s_read}, 32'd0);
        chk("reset rvalid", {30'd0, o_m0_rdatavalid, o_m1_rdatavalid}, 32'd0);
        reset_dut();

        // single write from m0, slave ready
        i_m0_write = 1; i_m0_addr = 8'h10; i_m0_wdata = 32'hA5A5_0001; i_m0_byte_en = 4'hF;
        sample();
        chk("t1 idle m0_wait", {31'd0, o_m0_waitrequest}, 32'd1);
        chk("t1 idle s_write", {31'd0, o_s_write}, 32'd0);
        next_cycle();
        sample();
        chk("t1 s_write", {31'd0, o_s_write}, 32'd1);
        chk("t1 s_addr", {24'd0, o_s_addr}, 32'h10);
        chk("t1 s_wdata", o_s_wdata, 32'hA5A5_0001);
        chk("t1 m0_wait", {31'd0, o_m0_waitrequest}, 32'd0);
        chk("t1 m1_wait", {31'd0, o_m1_waitrequest}, 32'd1);
        next_cycle();
        i_m0_write = 0;
        sample();
        chk("t1 after s_write", {31'd0, o_s_write}, 32'd0);
        next_cycle();

        // both masters read continuously, slave has one-cycle latency
        reset_dut();
        i_m0_read = 1; i_m0_addr = 8'h20; i_m1_read = 1; i_m1_addr = 8'h21;
        n_rv = 0; k = 0;
        for (int i = 0; i < 12; i++) begin
            sample();
            if (o_m0_rdatavalid) begin
                if (n_rv < 8) order[n_rv] = 0;
                n_rv++;
                chk("t2 m0 rdata", o_m0_rdata, 32'h1111);
            end
            if (o_m1_rdatavalid) begin
                if (n_rv < 8) order[n_rv] = 1;
                n_rv++;
                chk("t2 m1 rdata", o_m1_rdata, 32'h2222);
            end
            acc = o_s_read && !i_s_waitrequest;
            next_cycle();
            i_s_rdatavalid = acc;
            i_s_rdata = acc ? ((k % 2 == 0) ? 32'h1111 : 32'h2222) : 32'h0;
            if (acc) k++;
        end
        i_m0_read = 0; i_m1_read = 0; i_s_rdatavalid = 0; i_s_rdata = '0;
        chk("t2 responses", n_rv, 4);
        chk("t2 order0", order[0], 0);
        chk("t2 order1", order[1], 1);
        chk("t2 order2", order[2], 0);
        chk("t2 order3", order[3], 1);
        next_cycle();

        // m1 asserts write and read together: write wins
        i_m1_write = 1; i_m1_read = 1; i_m1_addr = 8'h30; i_m1_wdata = 32'hDEAD_BEEF; i_m1_byte_en = 4'h3;
        seen_wr = 0; seen_rd = 0; done = 0;
        for (int i = 0; i < 6 && !done; i++) begin
            sample();
            if (o_s_write) seen_wr++;
            if (o_s_read)  seen_rd++;
            if (!o_m1_waitrequest) done = 1;
            next_cycle();
        end
        i_m1_write = 0; i_m1_read = 0;
        chk("t3 accepted", {31'd0, done}, 32'd1);
        chk("t3 s_write cycles", seen_wr, 1);
        chk("t3 s_read cycles", seen_rd, 0);
        next_cycle();

        // m0 read with a slave that never answers
        i_m0_read = 1; i_m0_addr = 8'h40;
        next_cycle();
        sample();
        chk("t4 s_read", {31'd0, o_s_read}, 32'd1);
        chk("t4 m0_wait", {31'd0, o_m0_waitrequest}, 32'd0);
        next_cycle();
        i_m0_read = 0;
        pulse_at = -1;
        for (int n = 1; n <= 300 && pulse_at < 0; n++) begin
            sample();
            if (o_m0_rdatavalid) begin
                pulse_at = n;
                chk("t4 tmo rdata", o_m0_rdata, 32'h0);
                chk("t4 tmo pulse", {31'd0, o_rd_timeout}, 32'd1);
                chk("t4 tmo m1_rv", {31'd0, o_m1_rdatavalid}, 32'd0);
            end else begin
                next_cycle();
            end
        end
        chk("t4 timeout cycle", pulse_at, 256);
        next_cycle();
        sample();
        chk("t4 tmo after", {31'd0, o_rd_timeout}, 32'd0);
        repeat (4) next_cycle();
        i_s_rdatavalid = 1; i_s_rdata = 32'hBAD0_0BAD;
        sample();
        chk("t4 late rv", {30'd0, o_m0_rdatavalid, o_m1_rdatavalid}, 32'd0);
        chk("t4 late rdata", o_m0_rdata | o_m1_rdata, 32'h0);
        next_cycle();
        i_s_rdatavalid = 0; i_s_rdata = '0;
        next_cycle();

        // slave stalls the command for 4 cycles
        i_m0_write = 1; i_m0_addr = 8'h50; i_m0_wdata = 32'h1234_5678; i_m0_byte_en = 4'hC;
        i_s_waitrequest = 1;
        next_cycle();
        stable = 0; acc_at = -1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) i_s_waitrequest = 0;
            sample();
            if (o_s_write && o_s_addr == 8'h50 && o_s_wdata == 32'h1234_5678 && o_s_byte_en == 4'hC)
                stable++;
            if (!o_m0_waitrequest && acc_at < 0) acc_at = i;
            next_cycle();
        end
        i_m0_write = 0;
        chk("t5 stable cycles", stable, 5);
        chk("t5 accept cycle", acc_at, 4);
        next_cycle();

        // reset in the middle of a read wait
        i_m0_read = 1; i_m0_addr = 8'h60;
        next_cycle();
        next_cycle();
        i_m0_read = 0;
        next_cycle();
        #1 rst_n = 0;
        #1;
        chk("t6 rst m0_wait", {31'd0, o_m0_waitrequest}, 32'd1);
        chk("t6 rst m1_wait", {31'd0, o_m1_waitrequest}, 32'd1);
        chk("t6 rst s_cmd", {30'd0, o_s_write, o_s_read}, 32'd0);
        i_s_rdatavalid = 1; i_s_rdata = 32'h0000_0077;
        #1;
        chk("t6 rst rv", {30'd0, o_m0_rdatavalid, o_m1_rdatavalid}, 32'd0);
        chk("t6 rst tmo", {31'd0, o_rd_timeout}, 32'd0);
        next_cycle();
        i_s_rdatavalid = 0; i_s_rdata = '0;
        rst_n = 1;
        i_m0_write = 1; i_m0_addr = 8'h70; i_m1_write = 1; i_m1_addr = 8'h71;
        next_cycle();
        sample();
        chk("t6 tie to m0", {24'd0, o_s_addr}, 32'h70);
        next_cycle();
        i_m0_write = 0;
        next_cycle();
        sample();
        chk("t6 then m1", {24'd0, o_s_addr}, 32'h71);
        next_cycle();
        i_m1_write = 0;
        repeat (3) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aib_avmm_arb2.md
Name: aib_avmm_arb2

Overview:
- Two-master Avalon-MM arbiter that shares one 32-bit AVMM slave port between two requesters, e.g. the JTAG/config master and the user/adapter master.
- Sits in front of the AVMM-to-RDL interface block in each AIB channel's register path.
- Grant is round-robin and held for a full transaction: write until accepted, read until read data returns.
- A read-response timeout prevents a lost response from deadlocking the bus.

Parameters:
ADDR_WIDTH, 8, address width of both master ports and the slave port
TMO_WIDTH, 8, width of the read-timeout counter; timeout fires after 2**TMO_WIDTH-1 cycles

Ports:
avmm_clk  in  1  clock for all logic
avmm_rst_n  in  1  asynchronous active-low reset
i_m0_write / i_m1_write  in  1  master write request
i_m0_read / i_m1_read  in  1  master read request
i_m0_addr / i_m1_addr  in  ADDR_WIDTH  master address
i_m0_wdata / i_m1_wdata  in  32  master write data
i_m0_byte_en / i_m1_byte_en  in  4  master byte enables
o_m0_rdata / o_m1_rdata  out  32  read data returned to master
o_m0_rdatavalid / o_m1_rdatavalid  out  1  read data valid pulse
o_m0_waitrequest / o_m1_waitrequest  out  1  master waitrequest
o_s_write / o_s_read  out  1  slave command
o_s_addr  out  ADDR_WIDTH  slave address
o_s_wdata  out  32  slave write data
o_s_byte_en  out  4  slave byte enables
i_s_rdata  in  32  slave read data
i_s_rdatavalid  in  1  slave read data valid
i_s_waitrequest  in  1  slave waitrequest
o_rd_timeout  out  1  one-cycle pulse when a read times out

Behaviour:
- Reset: state=IDLE, last_grant=1 (so m0 wins the first tie), timeout counter=0.
  - Reset values of all outputs: both master waitrequests=1, rdatavalid=0, rdata=0; o_s_write/o_s_read=0, o_s_addr/o_s_wdata/o_s_byte_en=0; o_rd_timeout=0.
- Request definition: req_mX = i_mX_write | i_mX_read.
- IDLE:
  - If exactly one master requests, grant it.
  - If both request, grant the master other than last_grant.
  - Registered grant takes effect next cycle; move to CMD. No request: stay in IDLE.
- CMD:
  - Slave command/address/data/byte_en are muxed combinationally from the granted master; all slave command outputs are 0 outside CMD.
  - Write has priority: if both write and read are asserted, forward only the write (o_s_read=0).
  - o_mG_waitrequest = i_s_waitrequest for the granted master; the non-granted master's waitrequest stays 1.
  - On i_s_waitrequest=0 with a write: last_grant<=G, go to IDLE.
  - On i_s_waitrequest=0 with a read: clear the counter, go to RDWAIT.
  - If the granted master deasserts its request before acceptance (protocol violation): go to IDLE without updating last_grant.
- RDWAIT:
  - Slave command outputs are 0; both master waitrequests are 1.
  - On i_s_rdatavalid=1: o_mG_rdata=i_s_rdata and o_mG_rdatavalid=1 in the same cycle (combinational); last_grant<=G; go to IDLE.
  - Otherwise the counter increments.
  - When the counter reaches all-ones without valid: o_mG_rdatavalid=1 with o_mG_rdata=32'h0, o_rd_timeout=1 for that cycle, last_grant<=G, go to IDLE.
- i_s_rdatavalid in IDLE or CMD (late or stray response) is dropped and not forwarded.
- Non-granted master: rdatavalid=0 always.
- rdata is 0 whenever the corresponding rdatavalid=0.
- Minimum latencies:
  - Write: request to accept = 2 cycles when the slave has waitrequest low in CMD.
  - Read: one cycle in IDLE, one in CMD, then slave latency; 3 cycles against a one-cycle-latency slave.
- Back-to-back: after completion, IDLE re-arbitrates, so a pending other master is always served next (no starvation).
- Async reset asserted mid-transaction returns all state and outputs to reset values immediately; the in-flight transaction is abandoned and no rdatavalid is issued.
- Unused encodings of the 2-bit state return to IDLE.

Test Plan:
- m0 writes addr 8'h10, data 32'hA5A5_0001, slave waitrequest low in CMD -> o_s_write=1 with that addr/data for exactly 1 cycle; o_m0_waitrequest=0 for that one cycle, 2 cycles after request; m1 waitrequest stays 1.
- m0 and m1 both read continuously after reset; slave returns 32'h1111 then 32'h2222 with 1-cycle latency -> grant order m0, m1, m0, m1; o_m0_rdata=32'h1111, o_m1_rdata=32'h2222, each with a single rdatavalid pulse.
- m1 asserts write and read together -> only o_s_write is seen; o_s_read stays 0.
- m0 read; slave never returns rdatavalid -> after 255 cycles in RDWAIT: o_m0_rdatavalid=1, rdata=0, o_rd_timeout=1 for one cycle; a late i_s_rdatavalid 5 cycles later is not forwarded to either master.
- Slave holds waitrequest high 4 cycles in CMD -> slave command is stable for all 5 cycles; the master is accepted on the 5th cycle.
- avmm_rst_n pulsed low during RDWAIT -> outputs go to reset values immediately; no rdatavalid; the next tie is granted to m0.
